// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Shares one sequential multiplier between two requesters. A request is
// granted from IDLE with round-robin fairness. The winner's operands are
// latched onto the multiplier operand bus and the multiplier is started once
// it reports idle. The FSM then waits for completion, bounded by TIMEOUT
// cycles. A completed product is registered into Result and the owner gets a
// Vld pulse. A timeout instead gives the owner an Err pulse and pulses M_Rst
// to recover the multiplier.
//
// Parameters
//   W        operand width of the shared multiplier (product is 2*W)
//   TIMEOUT  number of WAIT cycles allowed before aborting (1..255)
//
// Ports
//   Clk, Reset                       clock, synchronous active-high reset
//   Req0/Req1, A0/B0, A1/B1          requests and operands from requesters
//   Gnt0/Gnt1                        one-cycle accept pulse to the winner
//   Vld0/Vld1                        one-cycle result-valid pulse to the owner
//   Err0/Err1                        one-cycle timeout-abort pulse to the owner
//   Result                           last captured product
//   Busy                             high while the FSM is outside IDLE
//   M_St, M_Rst                      start / recovery reset to the multiplier
//   M_Multiplicando, M_Multiplicador operands to the multiplier
//   M_Idle, M_Done, M_Produto        multiplier status and product
//
// Pulse timing: each pulse is registered when the FSM leaves the state that
// produces it. Gnt is therefore visible during the first ISSUE cycle. M_St is
// visible during the first WAIT cycle. Vld and Err are visible during the
// IDLE cycle that follows RESP or ABORT.
// -----------------------------------------------------------------------------
module mult_arbiter #(
   parameter int W       = 4,
   parameter int TIMEOUT = 15
) (
   input  logic           Clk,
   input  logic           Reset,
   input  logic           Req0,
   input  logic           Req1,
   input  logic [W-1:0]   A0,
   input  logic [W-1:0]   B0,
   input  logic [W-1:0]   A1,
   input  logic [W-1:0]   B1,
   output logic           Gnt0,
   output logic           Gnt1,
   output logic           Vld0,
   output logic           Vld1,
   output logic           Err0,
   output logic           Err1,
   output logic [2*W-1:0] Result,
   output logic           Busy,
   output logic           M_St,
   output logic           M_Rst,
   output logic [W-1:0]   M_Multiplicando,
   output logic [W-1:0]   M_Multiplicador,
   input  logic           M_Idle,
   input  logic           M_Done,
   input  logic [2*W-1:0] M_Produto
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP,
      S_ABORT
   } state_t;

   // The WAIT counter starts at 0, so its last legal value is TIMEOUT-1.
   // Completion in that final cycle still wins over the abort.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic       prio;   // requester that wins when both request
   logic       owner;  // requester of the transaction in flight
   logic [7:0] cnt;    // WAIT cycle counter
   logic       pick;   // requester that IDLE would grant this cycle

   // A lone requester always wins. On a tie, prio decides. prio is set to the
   // requester that was not served last.
   always_comb begin
      pick = 1'b0;
      if (Req0 && Req1) begin
         pick = prio;
      end else if (Req1) begin
         pick = 1'b1;
      end
   end

   assign Busy = (state != S_IDLE);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state           <= S_IDLE;
         prio            <= 1'b0;
         owner           <= 1'b0;
         cnt             <= '0;
         Result          <= '0;
         M_Multiplicando <= '0;
         M_Multiplicador <= '0;
         Gnt0            <= 1'b0;
         Gnt1            <= 1'b0;
         Vld0            <= 1'b0;
         Vld1            <= 1'b0;
         Err0            <= 1'b0;
         Err1            <= 1'b0;
         M_St            <= 1'b0;
         M_Rst           <= 1'b0;
      end else begin
         Gnt0  <= 1'b0;
         Gnt1  <= 1'b0;
         Vld0  <= 1'b0;
         Vld1  <= 1'b0;
         Err0  <= 1'b0;
         Err1  <= 1'b0;
         M_St  <= 1'b0;
         M_Rst <= 1'b0;

         case (state)
            S_IDLE: begin
               if (Req0 || Req1) begin
                  owner           <= pick;
                  M_Multiplicando <= pick ? A1 : A0;
                  M_Multiplicador <= pick ? B1 : B0;
                  Gnt0            <= ~pick;
                  Gnt1            <= pick;
                  state           <= S_ISSUE;
               end
            end

            // Hold off the start until the multiplier reports idle.
            S_ISSUE: begin
               if (M_Idle) begin
                  M_St  <= 1'b1;
                  cnt   <= '0;
                  state <= S_WAIT;
               end
            end

            S_WAIT: begin
               if (M_Done) begin
                  Result <= M_Produto;
                  state  <= S_RESP;
               end else if (cnt == CNT_LAST) begin
                  state <= S_ABORT;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end

            S_RESP: begin
               Vld0  <= ~owner;
               Vld1  <= owner;
               prio  <= ~owner;
               state <= S_IDLE;
            end

            // Result is deliberately left untouched on an abort.
            S_ABORT: begin
               Err0  <= ~owner;
               Err1  <= owner;
               M_Rst <= 1'b1;
               prio  <= ~owner;
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter
//
// Drives mult_arbiter through a behavioural multiplier and two requester
// models that each hold a job queue.
//
// A reference model tracks each transaction as cycle timestamps: grant,
// start and end. It derives every expected output for the next cycle from
// those timestamps. A compare process checks the DUT against the model once
// per cycle. Directed scenarios pin the model with hand-computed literals.
// A randomized phase follows them.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

   localparam int W       = 4;
   localparam int TIMEOUT = 15;

   logic           Clk = 1'b0;
   logic           Reset;
   logic           Req0, Req1;
   logic [W-1:0]   A0, B0, A1, B1;
   logic           Gnt0, Gnt1, Vld0, Vld1, Err0, Err1;
   logic [2*W-1:0] Result;
   logic           Busy, M_St, M_Rst;
   logic [W-1:0]   M_Multiplicando, M_Multiplicador;
   logic           M_Idle, M_Done;
   logic [2*W-1:0] M_Produto;

   mult_arbiter #(.W(W), .TIMEOUT(TIMEOUT)) dut (
      .Clk             (Clk),
      .Reset           (Reset),
      .Req0            (Req0),
      .Req1            (Req1),
      .A0              (A0),
      .B0              (B0),
      .A1              (A1),
      .B1              (B1),
      .Gnt0            (Gnt0),
      .Gnt1            (Gnt1),
      .Vld0            (Vld0),
      .Vld1            (Vld1),
      .Err0            (Err0),
      .Err1            (Err1),
      .Result          (Result),
      .Busy            (Busy),
      .M_St            (M_St),
      .M_Rst           (M_Rst),
      .M_Multiplicando (M_Multiplicando),
      .M_Multiplicador (M_Multiplicador),
      .M_Idle          (M_Idle),
      .M_Done          (M_Done),
      .M_Produto       (M_Produto)
   );

   always #5 Clk = ~Clk;

   int cyc = 0;
   always @(posedge Clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Requester job queues; each entry is {a, b}.
   logic [2*W-1:0] job0[$];
   logic [2*W-1:0] job1[$];

   // Behavioural multiplier.
   bit             mb = 0;
   int             rem = 0;
   logic [2*W-1:0] prod = '0;
   int             lat = 2;
   bit             never_done = 0;
   bit             stall_cfg = 0;
   int             stall = 0;
   bit             spur_en = 0;

   // Reference model: a transaction described by timestamps.
   bit         m_prio = 0, m_owner = 0, m_txn = 0, m_err = 0;
   int         m_tst = -1, m_tend = -1;
   logic [W-1:0] m_a = '0, m_b = '0;

   // Expected outputs for the coming cycle.
   logic e_gnt0, e_gnt1, e_vld0, e_vld1, e_err0, e_err1, e_mst, e_mrst, e_busy;
   logic [2*W-1:0] e_res;
   logic [W-1:0]   e_ma, e_mb;
   bit chk_en = 0;

   // Observed events, recorded by the compare process.
   int ev_who[$];
   int ev_res[$];
   int ev_cyc[$];
   int n_err = 0, err_who = 0, mrst_at_err = 0;
   int last_gnt = 0, last_st = 0, last_vld = 0, last_err = 0;

   // Called at a falling edge with Reset and the config already set. It
   // drives the remaining inputs for this cycle and advances the model.
   task automatic step();
      int          k;
      logic [31:0] r;
      bit          waiting;
      k = cyc;

      // Requesters: a granted job leaves its queue.
      if (Gnt0 === 1'b1 && job0.size() > 0) void'(job0.pop_front());
      if (Gnt1 === 1'b1 && job1.size() > 0) void'(job1.pop_front());
      r = $urandom;
      Req0 = (job0.size() > 0);
      Req1 = (job1.size() > 0);
      {A0, B0} = Req0 ? job0[0] : r[7:0];
      {A1, B1} = Req1 ? job1[0] : r[15:8];

      // Multiplier: done L cycles after the start it saw.
      waiting = m_txn && (m_tst >= 0) && (m_tend < 0);
      r = $urandom;
      M_Done = 1'b0;
      M_Produto = r[2*W-1:0];
      if (mb) begin
         if (rem == 0) begin
            M_Done = 1'b1;
            M_Produto = prod;
            mb = 0;
         end else begin
            rem--;
         end
      end
      if (M_St === 1'b1) begin
         mb = 1;
         rem = never_done ? 100000 : lat - 1;
         prod = {{W{1'b0}}, M_Multiplicando} * {{W{1'b0}}, M_Multiplicador};
      end
      if (stall_cfg && (Gnt0 === 1'b1 || Gnt1 === 1'b1)) stall = 3;
      M_Idle = !mb && (stall == 0);
      if (stall > 0) stall--;
      if (spur_en && !waiting && !M_Done && r[27:26] == 2'b00) begin
         M_Done = 1'b1;
      end
      if (Reset || M_Rst === 1'b1) mb = 0;

      // Reference model.
      if (Reset) begin
         m_prio = 0; m_txn = 0; m_tst = -1; m_tend = -1;
         {e_gnt0, e_gnt1, e_vld0, e_vld1, e_err0, e_err1, e_mst, e_mrst, e_busy} = '0;
         e_res = '0; e_ma = '0; e_mb = '0;
      end else begin
         {e_gnt0, e_gnt1, e_vld0, e_vld1, e_err0, e_err1, e_mst, e_mrst} = '0;
         if (m_txn && m_tend == k) m_txn = 0;
         if (!m_txn) begin
            if (Req0 || Req1) begin
               m_owner = (Req0 && Req1) ? m_prio : Req1;
               m_a = m_owner ? A1 : A0;
               m_b = m_owner ? B1 : B0;
               e_ma = m_a; e_mb = m_b;
               m_txn = 1; m_tst = -1; m_tend = -1;
               if (m_owner) e_gnt1 = 1'b1; else e_gnt0 = 1'b1;
            end
         end else if (m_tst < 0) begin
            if (M_Idle) begin
               m_tst = k + 1;
               e_mst = 1'b1;
            end
         end else if (m_tend < 0) begin
            if (M_Done) begin
               e_res = {{W{1'b0}}, m_a} * {{W{1'b0}}, m_b};
               m_tend = k + 2; m_err = 0;
            end else if (k - m_tst == TIMEOUT - 1) begin
               m_tend = k + 2; m_err = 1;
            end
         end
         if (m_txn && m_tend == k + 1) begin
            if (m_err) begin
               if (m_owner) e_err1 = 1'b1; else e_err0 = 1'b1;
               e_mrst = 1'b1;
            end else begin
               if (m_owner) e_vld1 = 1'b1; else e_vld0 = 1'b1;
            end
            m_prio = !m_owner;
         end
         e_busy = m_txn && (m_tend < 0 || k + 1 < m_tend);
      end
      chk_en = 1;
   endtask

   task automatic run(input int n);
      repeat (n) begin
         step();
         @(negedge Clk);
      end
   endtask

   task automatic wait_events(input int target, input string name);
      int i;
      i = 0;
      while (ev_who.size() + n_err < target && i < 100) begin
         step();
         @(negedge Clk);
         i++;
      end
      chk(name, ev_who.size() + n_err, target);
   endtask

   // Compare process: DUT outputs against the model, every cycle.
   always @(posedge Clk) begin
      #2;
      if (chk_en) begin
         chk("pulses", {Gnt0, Gnt1, Vld0, Vld1, Err0, Err1, M_St, M_Rst, Busy},
             {e_gnt0, e_gnt1, e_vld0, e_vld1, e_err0, e_err1, e_mst, e_mrst, e_busy});
         chk("result", Result, e_res);
         chk("operands", {M_Multiplicando, M_Multiplicador}, {e_ma, e_mb});
         chk("one_pulse", ($countones({Gnt0, Gnt1, Vld0, Vld1, Err0, Err1}) <= 1), 1);
      end
      if (Gnt0 === 1'b1 || Gnt1 === 1'b1) last_gnt = cyc;
      if (M_St === 1'b1) last_st = cyc;
      if (Vld0 === 1'b1 || Vld1 === 1'b1) begin
         last_vld = cyc;
         ev_who.push_back(int'(Vld1));
         ev_res.push_back(int'(Result));
         ev_cyc.push_back(cyc);
      end
      if (Err0 === 1'b1 || Err1 === 1'b1) begin
         last_err = cyc;
         n_err++;
         err_who = int'(Err1);
         mrst_at_err = int'(M_Rst);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base, nv, ne;
      logic [31:0] r, r2;
      Reset = 1'b1; Req0 = 0; Req1 = 0; A0 = 0; B0 = 0; A1 = 0; B1 = 0;
      M_Idle = 1'b1; M_Done = 1'b0; M_Produto = '0;
      @(negedge Clk);
      run(3);
      chk("reset busy", Busy, 0);
      chk("reset result", Result, 0);
      Reset = 1'b0;
      run(2);

      // Single request 3*5.
      lat = 2;
      base = ev_who.size();
      job0.push_back({4'd3, 4'd5});
      wait_events(base + 1, "s1 done");
      chk("s1 owner", ev_who[base], 0);
      chk("s1 result", ev_res[base], 15);
      chk("s1 start latency", last_st - last_gnt, 1);
      chk("s1 valid latency", last_vld - last_gnt, 5);
      run(1);
      chk("s1 busy after", Busy, 0);

      // Simultaneous requests after reset.
      Reset = 1'b1; run(2); Reset = 1'b0;
      base = ev_who.size() + n_err;
      job0.push_back({4'd2, 4'd7});
      job1.push_back({4'd15, 4'd15});
      wait_events(base + 2, "s2 done");
      chk("s2 first owner", ev_who[base], 0);
      chk("s2 first result", ev_res[base], 14);
      chk("s2 second owner", ev_who[base + 1], 1);
      chk("s2 second result", ev_res[base + 1], 225);
      job0.push_back({4'd2, 4'd7});
      job1.push_back({4'd15, 4'd15});
      wait_events(base + 4, "s2 again");
      chk("s2 favours 0", ev_who[base + 2], 0);
      chk("s2 then 1", ev_who[base + 3], 1);

      // Multiplier busy for 3 cycles after grant.
      stall_cfg = 1; lat = 3;
      base = ev_who.size() + n_err;
      job1.push_back({4'd9, 4'd11});
      wait_events(base + 1, "s3 done");
      stall_cfg = 0;
      chk("s3 start delay", last_st - last_gnt, 4);
      chk("s3 result", ev_res[ev_who.size() - 1], 99);

      // Timeout: no completion.
      never_done = 1;
      nv = ev_who.size();
      job0.push_back({4'd6, 4'd7});
      wait_events(nv + n_err + 1, "s4 abort");
      never_done = 0;
      chk("s4 no valid", ev_who.size(), nv);
      chk("s4 err owner", err_who, 0);
      chk("s4 err delay", last_err - last_st, 16);
      chk("s4 m_rst", mrst_at_err, 1);
      chk("s4 result kept", Result, 99);
      run(1);
      chk("s4 idle", Busy, 0);

      // Completion in the last WAIT cycle, then one cycle too late.
      lat = 14;
      base = ev_who.size() + n_err;
      job1.push_back({4'd5, 4'd3});
      wait_events(base + 1, "s5 late done");
      chk("s5 result", ev_res[ev_who.size() - 1], 15);
      chk("s5 valid delay", last_vld - last_st, 16);
      lat = 15;
      ne = n_err;
      job0.push_back({4'd4, 4'd4});
      wait_events(base + 2, "s5 too late");
      chk("s5 aborted", n_err, ne + 1);
      chk("s5 result kept", Result, 15);

      // Reset during WAIT.
      never_done = 1; lat = 2;
      job0.push_back({4'd7, 4'd7});
      run(6);
      nv = ev_who.size(); ne = n_err;
      Reset = 1'b1; run(1); Reset = 1'b0;
      never_done = 0;
      chk("s6 busy", Busy, 0);
      chk("s6 result", Result, 0);
      run(20);
      chk("s6 silent valid", ev_who.size(), nv);
      chk("s6 silent err", n_err, ne);
      job1.push_back({4'd2, 4'd3});
      wait_events(nv + ne + 1, "s6 resume");
      chk("s6 owner", ev_who[nv], 1);
      chk("s6 result after", ev_res[nv], 6);

      // Req1 held continuously.
      lat = 1;
      base = ev_who.size();
      repeat (4) job1.push_back({4'd1, 4'd1});
      wait_events(base + n_err + 4, "s7 done");
      for (int i = 0; i < 4; i++) begin
         chk("s7 owner", ev_who[base + i], 1);
         chk("s7 result", ev_res[base + i], 1);
      end
      for (int i = 1; i < 4; i++) chk("s7 spacing", ev_cyc[base + i] - ev_cyc[base + i - 1], 5);

      // Randomized traffic.
      spur_en = 1;
      for (int n = 0; n < 2500; n++) begin
         r = $urandom;
         r2 = $urandom;
         if (r[2:0] == 3'd0 && job0.size() < 3) job0.push_back(r2[7:0]);
         if (r[5:3] == 3'd0 && job1.size() < 3) job1.push_back(r2[15:8]);
         lat = 1 + int'(r[8:6]);
         stall_cfg = (r[11:9] == 3'd0);
         never_done = (r[17:12] == 6'd0);
         Reset = (r[25:18] == 8'd0);
         step();
         @(negedge Clk);
      end
      Reset = 1'b0; never_done = 0; stall_cfg = 0; spur_en = 0; lat = 2;
      begin
         int i;
         i = 0;
         while ((job0.size() > 0 || job1.size() > 0 || Busy === 1'b1) && i < 500) begin
            step();
            @(negedge Clk);
            i++;
         end
      end
      chk("drain", job0.size() + job1.size() + int'(Busy), 0);
      run(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
